// File: rtl/exu_cp0_sched_pkg.sv
// Shared types and constants for the CP0 serialising scheduler.
package exu_cp0_pkg;

   localparam int unsigned IID_W  = 5;
   localparam int unsigned OP_W   = 7;
   localparam int unsigned DATA_W = 64;

   // Environment-call opcode and the immediate flag that marks an ebreak.
   localparam logic [OP_W-1:0]   I_ENV          = 7'b1110011;
   localparam logic [DATA_W-1:0] ENVFLAG_EBREAK = 64'd1;

   typedef struct packed {
      logic [IID_W-1:0]  iid;
      logic [OP_W-1:0]   opcode;
      logic              psrc1_vld;
      logic [DATA_W-1:0] psrc1_value;
      logic              imm_vld;
      logic [DATA_W-1:0] imm;
   } cp0_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT
   } cp0_state_t;

endpackage

// File: rtl/exu_cp0_sched_if.sv
// Dispatch, ROB-head, issue and completion signals around the CP0 scheduler.
interface exu_cp0_sched_if
   import exu_cp0_pkg::*;
#(
   parameter int unsigned DEPTH = 4
);

   logic                     rtu_global_flush;

   logic                     idu_sched_cp0_vld;
   logic [IID_W-1:0]         idu_sched_cp0_iid;
   logic [OP_W-1:0]          idu_sched_cp0_opcode;
   logic                     idu_sched_cp0_psrc1_vld;
   logic [DATA_W-1:0]        idu_sched_cp0_psrc1_value;
   logic                     idu_sched_cp0_imm_vld;
   logic [DATA_W-1:0]        idu_sched_cp0_imm;
   logic                     sched_idu_cp0_rdy;

   logic                     rtu_rob_head_vld;
   logic [IID_W-1:0]         rtu_rob_head_iid;

   logic                     sched_cp0_vld;
   logic [IID_W-1:0]         sched_cp0_iid;
   logic [OP_W-1:0]          sched_cp0_opcode;
   logic                     sched_cp0_psrc1_vld;
   logic [DATA_W-1:0]        sched_cp0_psrc1_value;
   logic                     sched_cp0_imm_vld;
   logic [DATA_W-1:0]        sched_cp0_imm;

   logic                     exu_rtu_rob_cp0_complete;
   logic [IID_W-1:0]         exu_rtu_rob_cp0_iid;

   logic                     sched_cp0_busy;
   logic [$clog2(DEPTH):0]   sched_cp0_cnt;
   logic                     sched_cp0_err;

   // Scheduler side.
   modport slave (
      input  rtu_global_flush,
      input  idu_sched_cp0_vld, idu_sched_cp0_iid, idu_sched_cp0_opcode,
             idu_sched_cp0_psrc1_vld, idu_sched_cp0_psrc1_value,
             idu_sched_cp0_imm_vld, idu_sched_cp0_imm,
      output sched_idu_cp0_rdy,
      input  rtu_rob_head_vld, rtu_rob_head_iid,
      output sched_cp0_vld, sched_cp0_iid, sched_cp0_opcode,
             sched_cp0_psrc1_vld, sched_cp0_psrc1_value,
             sched_cp0_imm_vld, sched_cp0_imm,
      input  exu_rtu_rob_cp0_complete, exu_rtu_rob_cp0_iid,
      output sched_cp0_busy, sched_cp0_cnt, sched_cp0_err
   );

   // Environment side (IDU, RTU, CP0 unit).
   modport master (
      output rtu_global_flush,
      output idu_sched_cp0_vld, idu_sched_cp0_iid, idu_sched_cp0_opcode,
             idu_sched_cp0_psrc1_vld, idu_sched_cp0_psrc1_value,
             idu_sched_cp0_imm_vld, idu_sched_cp0_imm,
      input  sched_idu_cp0_rdy,
      output rtu_rob_head_vld, rtu_rob_head_iid,
      input  sched_cp0_vld, sched_cp0_iid, sched_cp0_opcode,
             sched_cp0_psrc1_vld, sched_cp0_psrc1_value,
             sched_cp0_imm_vld, sched_cp0_imm,
      output exu_rtu_rob_cp0_complete, exu_rtu_rob_cp0_iid,
      input  sched_cp0_busy, sched_cp0_cnt, sched_cp0_err
   );

endinterface

// File: rtl/exu_cp0_sched_fifo.sv
// In-order circular queue of CP0 entries; pointers carry a wrap bit.
module exu_cp0_sched_fifo
   import exu_cp0_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_clk,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  cp0_entry_t             push_data_i,
   input  logic                   pop_i,
   output cp0_entry_t             head_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic [$clog2(DEPTH):0] cnt_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   cp0_entry_t  mem_q [DEPTH];
   logic        push_ok, pop_ok;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
   assign cnt_o   = wptr_q - rptr_q;
   assign head_o  = mem_q[rptr_q[AW-1:0]];
   assign push_ok = push_i && !full_o && !flush_i;
   assign pop_ok  = pop_i && !empty_o && !flush_i;

   // Next pointers: flush empties the queue, otherwise advance on push/pop.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + (AW+1)'(1);
         if (pop_ok)  rptr_d = rptr_q + (AW+1)'(1);
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_clk) begin
      if (!rst_clk) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Entry storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/exu_cp0_sched.sv
// Serialising CP0 scheduler: issues queued CP0 ops only at the ROB head,
// one in flight, with a completion watchdog and global-flush recovery.
module exu_cp0_sched
   import exu_cp0_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TMO_CYC = 15
) (
   input logic                clk,
   input logic                rst_clk,
   exu_cp0_sched_if.slave     bus
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned WD_W  = $clog2(TMO_CYC + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TMO_CYC);

   cp0_state_t       state_q, state_d;
   logic [WD_W-1:0]  wdog_q, wdog_d;
   logic             err_q, err_d;
   cp0_entry_t       iss_q, iss_d;

   cp0_entry_t       push_data, fifo_head, iss_out;
   logic             fifo_empty, fifo_full;
   logic [CNT_W-1:0] fifo_cnt;
   logic             push, pop, rdy;
   logic             head_ok, cmpl_hit, cmpl_bad, issue_vld;

   assign push_data = '{iid:         bus.idu_sched_cp0_iid,
                        opcode:      bus.idu_sched_cp0_opcode,
                        psrc1_vld:   bus.idu_sched_cp0_psrc1_vld,
                        psrc1_value: bus.idu_sched_cp0_psrc1_value,
                        imm_vld:     bus.idu_sched_cp0_imm_vld,
                        imm:         bus.idu_sched_cp0_imm};

   assign rdy  = !fifo_full && !bus.rtu_global_flush;
   assign push = bus.idu_sched_cp0_vld && rdy;

   exu_cp0_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_clk     (rst_clk),
      .flush_i     (bus.rtu_global_flush),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (fifo_head),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full),
      .cnt_o       (fifo_cnt)
   );

   assign head_ok  = !fifo_empty && bus.rtu_rob_head_vld &&
                     (bus.rtu_rob_head_iid == fifo_head.iid);
   assign cmpl_hit = bus.exu_rtu_rob_cp0_complete && (bus.exu_rtu_rob_cp0_iid == iss_q.iid);
   assign cmpl_bad = bus.exu_rtu_rob_cp0_complete && !cmpl_hit;

   // Issue FSM and watchdog next-state; flush overrides all but the sticky error.
   always_comb begin
      state_d = state_q;
      wdog_d  = wdog_q;
      err_d   = err_q;
      iss_d   = iss_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            wdog_d = '0;
            if (head_ok) begin
               pop     = 1'b1;
               iss_d   = fifo_head;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE, ST_WAIT: begin
            wdog_d = (state_q == ST_ISSUE) ? '0 : wdog_q + WD_W'(1);
            if (cmpl_hit) begin
               state_d = ST_IDLE;
               wdog_d  = '0;
            end else begin
               if (cmpl_bad) err_d = 1'b1;
               if ((state_q == ST_WAIT) && (wdog_q == WD_LIMIT)) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
                  wdog_d  = '0;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            wdog_d  = '0;
         end
      endcase
      if (bus.rtu_global_flush) begin
         state_d = ST_IDLE;
         wdog_d  = '0;
         err_d   = err_q;
         pop     = 1'b0;
      end
   end

   // FSM, watchdog, error and issued-payload registers.
   always_ff @(posedge clk or negedge rst_clk) begin
      if (!rst_clk) begin
         state_q <= ST_IDLE;
         wdog_q  <= '0;
         err_q   <= 1'b0;
         iss_q   <= '0;
      end else begin
         state_q <= state_d;
         wdog_q  <= wdog_d;
         err_q   <= err_d;
         iss_q   <= iss_d;
      end
   end

   assign issue_vld = (state_q == ST_ISSUE);
   assign iss_out   = issue_vld ? iss_q : '0;

   assign bus.sched_idu_cp0_rdy     = rdy;
   assign bus.sched_cp0_vld         = issue_vld;
   assign bus.sched_cp0_iid         = iss_out.iid;
   assign bus.sched_cp0_opcode      = iss_out.opcode;
   assign bus.sched_cp0_psrc1_vld   = iss_out.psrc1_vld;
   assign bus.sched_cp0_psrc1_value = iss_out.psrc1_value;
   assign bus.sched_cp0_imm_vld     = iss_out.imm_vld;
   assign bus.sched_cp0_imm         = iss_out.imm;
   assign bus.sched_cp0_busy        = (state_q != ST_IDLE);
   assign bus.sched_cp0_cnt         = fifo_cnt;
   assign bus.sched_cp0_err         = err_q;

endmodule

// File: tb/tb_exu_cp0_sched.sv
// Bench for exu_cp0_sched: directed scenarios then random traffic, all
// outputs compared every cycle against a queue-based reference model.
module tb_exu_cp0_sched;
   import exu_cp0_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 15;

   logic clk = 1'b0;
   logic rst_clk;
   always #5 clk = ~clk;

   exu_cp0_sched_if #(.DEPTH(DEPTH)) bus ();

   exu_cp0_sched #(.DEPTH(DEPTH), .TMO_CYC(TMO)) dut (
      .clk     (clk),
      .rst_clk (rst_clk),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: pending ops, the op being issued/awaited, sticky error.
   cp0_entry_t mq[$];
   bit         m_iss, m_wt, m_err;
   cp0_entry_t m_pay;
   int         m_iss_at;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic cp0_entry_t obs_pay();
      cp0_entry_t e;
      e.iid         = bus.sched_cp0_iid;
      e.opcode      = bus.sched_cp0_opcode;
      e.psrc1_vld   = bus.sched_cp0_psrc1_vld;
      e.psrc1_value = bus.sched_cp0_psrc1_value;
      e.imm_vld     = bus.sched_cp0_imm_vld;
      e.imm         = bus.sched_cp0_imm;
      return e;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_iss    = 0;
      m_wt     = 0;
      m_err    = 0;
      m_pay    = '0;
      m_iss_at = 0;
   endtask

   task automatic check_all();
      cp0_entry_t exp_pay;
      exp_pay = m_iss ? m_pay : '0;
      chk("rdy",     256'(bus.sched_idu_cp0_rdy), 256'((mq.size() < DEPTH) && !bus.rtu_global_flush));
      chk("cnt",     256'(bus.sched_cp0_cnt),     256'(mq.size()));
      chk("vld",     256'(bus.sched_cp0_vld),     256'(m_iss));
      chk("payload", 256'(obs_pay()),             256'(exp_pay));
      chk("busy",    256'(bus.sched_cp0_busy),    256'(m_iss || m_wt));
      chk("err",     256'(bus.sched_cp0_err),     256'(m_err));
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      bit         rdy_e, popped, done;
      int         waited;
      cp0_entry_t pe, ne;
      rdy_e  = (mq.size() < DEPTH) && !bus.rtu_global_flush;
      popped = 0;
      if (!rst_clk) begin
         model_reset();
         return;
      end
      if (bus.idu_sched_cp0_vld && !rdy_e)
         $display("protocol note: dispatch iid=%0d while not ready, dropped", bus.idu_sched_cp0_iid);
      if (bus.rtu_global_flush) begin
         mq.delete();
         m_iss = 0;
         m_wt  = 0;
         return;
      end
      if (!m_iss && !m_wt) begin
         if (mq.size() > 0 && bus.rtu_rob_head_vld && bus.rtu_rob_head_iid == mq[0].iid) begin
            pe     = mq.pop_front();
            popped = 1;
         end
      end else begin
         done   = bus.exu_rtu_rob_cp0_complete && (bus.exu_rtu_rob_cp0_iid == m_pay.iid);
         waited = cyc - m_iss_at - 1;
         if (done) begin
            m_wt = 0;
         end else begin
            if (bus.exu_rtu_rob_cp0_complete) m_err = 1;
            if (m_wt && waited == int'(TMO)) begin
               m_err = 1;
               m_wt  = 0;
            end else begin
               m_wt = 1;
            end
         end
         m_iss = 0;
      end
      if (popped) begin
         m_pay    = pe;
         m_iss    = 1;
         m_iss_at = cyc + 1;
      end
      if (bus.idu_sched_cp0_vld && rdy_e) begin
         ne.iid         = bus.idu_sched_cp0_iid;
         ne.opcode      = bus.idu_sched_cp0_opcode;
         ne.psrc1_vld   = bus.idu_sched_cp0_psrc1_vld;
         ne.psrc1_value = bus.idu_sched_cp0_psrc1_value;
         ne.imm_vld     = bus.idu_sched_cp0_imm_vld;
         ne.imm         = bus.idu_sched_cp0_imm;
         mq.push_back(ne);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_all();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      bus.idu_sched_cp0_vld        = 1'b0;
      bus.exu_rtu_rob_cp0_complete = 1'b0;
      bus.rtu_global_flush         = 1'b0;
   endtask

   task automatic dispatch(input logic [IID_W-1:0] iid);
      bus.idu_sched_cp0_vld         = 1'b1;
      bus.idu_sched_cp0_iid         = iid;
      bus.idu_sched_cp0_opcode      = OP_W'($urandom);
      bus.idu_sched_cp0_psrc1_vld   = 1'($urandom);
      bus.idu_sched_cp0_psrc1_value = {$urandom, $urandom};
      bus.idu_sched_cp0_imm_vld     = 1'($urandom);
      bus.idu_sched_cp0_imm         = {$urandom, $urandom};
   endtask

   task automatic cmpl(input logic [IID_W-1:0] iid);
      bus.exu_rtu_rob_cp0_complete = 1'b1;
      bus.exu_rtu_rob_cp0_iid      = iid;
   endtask

   task automatic wait_pulse(input string tag, input logic [IID_W-1:0] iid);
      for (int i = 0; i < 8 && !bus.sched_cp0_vld; i++) tick();
      chk({tag, "_vld"}, 256'(bus.sched_cp0_vld), 256'(1));
      chk({tag, "_iid"}, 256'(bus.sched_cp0_iid), 256'(iid));
   endtask

   initial begin
      rst_clk                       = 1'b0;
      bus.rtu_global_flush          = 1'b0;
      bus.idu_sched_cp0_vld         = 1'b0;
      bus.idu_sched_cp0_iid         = '0;
      bus.idu_sched_cp0_opcode      = '0;
      bus.idu_sched_cp0_psrc1_vld   = 1'b0;
      bus.idu_sched_cp0_psrc1_value = '0;
      bus.idu_sched_cp0_imm_vld     = 1'b0;
      bus.idu_sched_cp0_imm         = '0;
      bus.rtu_rob_head_vld          = 1'b0;
      bus.rtu_rob_head_iid          = '0;
      bus.exu_rtu_rob_cp0_complete  = 1'b0;
      bus.exu_rtu_rob_cp0_iid       = '0;
      model_reset();

      // Reset values.
      #2;
      chk("rst_rdy", 256'(bus.sched_idu_cp0_rdy), 256'(1));
      chk("rst_cnt", 256'(bus.sched_cp0_cnt), 256'(0));
      tick();
      tick();
      rst_clk = 1'b1;

      // Single ebreak: pulse two cycles after dispatch, completion next cycle.
      bus.rtu_rob_head_vld = 1'b1;
      bus.rtu_rob_head_iid = 5'd3;
      dispatch(5'd3);
      bus.idu_sched_cp0_opcode  = I_ENV;
      bus.idu_sched_cp0_imm_vld = 1'b1;
      bus.idu_sched_cp0_imm     = ENVFLAG_EBREAK;
      tick();
      tick();
      chk("s1_pulse", 256'(bus.sched_cp0_vld), 256'(1));
      chk("s1_iid",   256'(bus.sched_cp0_iid), 256'(3));
      chk("s1_op",    256'(bus.sched_cp0_opcode), 256'(I_ENV));
      tick();
      cmpl(5'd3);
      tick();
      chk("s1_busy", 256'(bus.sched_cp0_busy), 256'(0));
      chk("s1_err",  256'(bus.sched_cp0_err), 256'(0));

      // Not the oldest: stays queued until the ROB head matches.
      bus.rtu_rob_head_iid = 5'd5;
      dispatch(5'd7);
      tick();
      repeat (10) tick();
      chk("s2_cnt",  256'(bus.sched_cp0_cnt), 256'(1));
      chk("s2_hold", 256'(bus.sched_cp0_vld), 256'(0));
      bus.rtu_rob_head_iid = 5'd7;
      tick();
      chk("s2_pulse", 256'(bus.sched_cp0_vld), 256'(1));
      chk("s2_iid",   256'(bus.sched_cp0_iid), 256'(7));
      tick();
      cmpl(5'd7);
      tick();
      tick();

      // Fill, drop one, then drain in order.
      bus.rtu_rob_head_iid = 5'd20;
      for (int k = 1; k <= 4; k++) begin
         dispatch(IID_W'(k));
         tick();
      end
      chk("s3_full_rdy", 256'(bus.sched_idu_cp0_rdy), 256'(0));
      chk("s3_full_cnt", 256'(bus.sched_cp0_cnt), 256'(4));
      dispatch(5'd5);
      tick();
      chk("s3_drop_cnt", 256'(bus.sched_cp0_cnt), 256'(4));
      bus.rtu_rob_head_iid = 5'd1;
      tick();
      chk("s3_rdy_back", 256'(bus.sched_idu_cp0_rdy), 256'(1));
      chk("s3_cnt_back", 256'(bus.sched_cp0_cnt), 256'(3));
      for (int k = 1; k <= 4; k++) begin
         wait_pulse("s3_order", IID_W'(k));
         tick();
         cmpl(IID_W'(k));
         bus.rtu_rob_head_iid = IID_W'(k + 1);
         tick();
      end
      chk("s3_empty", 256'(bus.sched_cp0_cnt), 256'(0));

      // Flush while waiting: everything cleared, late completion ignored.
      bus.rtu_rob_head_iid = 5'd8;
      dispatch(5'd8);
      tick();
      dispatch(5'd9);
      tick();
      wait_pulse("s4_issue", 5'd8);
      tick();
      bus.rtu_global_flush = 1'b1;
      tick();
      chk("s4_cnt",  256'(bus.sched_cp0_cnt), 256'(0));
      chk("s4_busy", 256'(bus.sched_cp0_busy), 256'(0));
      chk("s4_vld",  256'(bus.sched_cp0_vld), 256'(0));
      cmpl(5'd8);
      bus.rtu_rob_head_iid = 5'd9;
      tick();
      repeat (4) tick();
      chk("s4_err",     256'(bus.sched_cp0_err), 256'(0));
      chk("s4_noissue", 256'(bus.sched_cp0_busy), 256'(0));

      // Watchdog expiry, then normal issue with sticky error.
      bus.rtu_rob_head_iid = 5'd2;
      dispatch(5'd2);
      tick();
      dispatch(5'd11);
      tick();
      wait_pulse("s5_issue", 5'd2);
      repeat (TMO + 1) tick();
      chk("s5_pre_err",  256'(bus.sched_cp0_err), 256'(0));
      chk("s5_pre_busy", 256'(bus.sched_cp0_busy), 256'(1));
      tick();
      chk("s5_err",  256'(bus.sched_cp0_err), 256'(1));
      chk("s5_idle", 256'(bus.sched_cp0_busy), 256'(0));
      bus.rtu_rob_head_iid = 5'd11;
      wait_pulse("s5_next", 5'd11);
      tick();
      cmpl(5'd11);
      tick();
      chk("s5_sticky", 256'(bus.sched_cp0_err), 256'(1));

      // Asynchronous reset in the issue cycle kills the pulse at once.
      bus.rtu_rob_head_iid = 5'd13;
      dispatch(5'd13);
      tick();
      tick();
      chk("s6_pre_vld", 256'(bus.sched_cp0_vld), 256'(1));
      rst_clk = 1'b0;
      #1;
      chk("s6_rst_vld", 256'(bus.sched_cp0_vld), 256'(0));
      chk("s6_rst_err", 256'(bus.sched_cp0_err), 256'(0));
      chk("s6_rst_cnt", 256'(bus.sched_cp0_cnt), 256'(0));
      model_reset();
      tick();
      tick();
      rst_clk = 1'b1;

      // Mismatched completion flags error but keeps waiting.
      bus.rtu_rob_head_iid = 5'd4;
      dispatch(5'd4);
      tick();
      wait_pulse("s7_issue", 5'd4);
      tick();
      cmpl(5'd6);
      tick();
      chk("s7_err",  256'(bus.sched_cp0_err), 256'(1));
      chk("s7_busy", 256'(bus.sched_cp0_busy), 256'(1));
      cmpl(5'd4);
      tick();
      chk("s7_done", 256'(bus.sched_cp0_busy), 256'(0));

      // Random traffic from a clean reset.
      rst_clk = 1'b0;
      #1;
      model_reset();
      tick();
      rst_clk = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         if ((mq.size() < DEPTH || $urandom_range(0, 9) == 0) && $urandom_range(0, 99) < 45)
            dispatch(IID_W'($urandom_range(0, 31)));
         bus.rtu_rob_head_vld = ($urandom_range(0, 9) != 0);
         if (mq.size() > 0 && $urandom_range(0, 99) < 70)
            bus.rtu_rob_head_iid = mq[0].iid;
         else
            bus.rtu_rob_head_iid = IID_W'($urandom_range(0, 31));
         if ((m_iss || m_wt) && $urandom_range(0, 99) < 25)
            cmpl(($urandom_range(0, 99) < 92) ? m_pay.iid : m_pay.iid + IID_W'(1));
         if ($urandom_range(0, 99) < 3)
            bus.rtu_global_flush = 1'b1;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
